// File: rtl/id_issue_queue.sv
// id_issue_queue
// Decode/issue buffer sitting between IF/ID and ID/EX. Fetched instructions
// wait in a small FIFO; the head is decoded combinationally, checked against
// a scoreboard of in-flight register writes, and issued in order into a
// registered valid/ready output stage. A flush from EX empties the queue and
// kills the instruction held in the output stage.
module id_issue_queue #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int DEPTH    = 4,
    parameter int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         if_valid,
    output logic                         if_ready,
    input  logic [31:0]                  if_ir,
    input  logic [XLEN-1:0]              if_ia_plus_4,
    input  logic                         wb_valid,
    input  logic [REG_AW-1:0]            wb_addr,
    output logic                         ex_valid,
    input  logic                         ex_ready,
    output logic [31:0]                  ex_ir,
    output logic [XLEN-1:0]              ex_ia_plus_4,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         stall_hazard
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [6:0] OPC_STORE  = 7'b1001001;
    localparam logic [6:0] OPC_BRANCH = 7'b1111111;
    localparam logic [5:0] OPC_NOSRC  = 6'b111110;

    // FIFO storage (data only, never reset) and control state
    logic [31:0]     fifo_ir [DEPTH];
    logic [XLEN-1:0] fifo_ia [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // Scoreboard: one bit per architectural register with a write in flight
    logic [NUM_REGS-1:0] scoreboard;
    logic [NUM_REGS-1:0] scoreboard_next;

    // Destination of the instruction held in the output stage (0 = none)
    logic [REG_AW-1:0] ex_dest_p1;

    // Head-of-queue decode (stage p0)
    logic [31:0]       head_ir_p0;
    logic [XLEN-1:0]   head_ia_p0;
    logic [6:0]        opc_p0;
    logic [REG_AW-1:0] ra_p0;
    logic [REG_AW-1:0] rb_p0;
    logic [REG_AW-1:0] rd_p0;
    logic [REG_AW-1:0] src_b_p0;
    logic [REG_AW-1:0] dest_p0;
    logic              src_a_en_p0;
    logic              src_b_en_p0;
    logic              wr_en_p0;
    logic              wr_eff_p0;
    logic              hazard_p0;

    logic head_vld_p0;
    logic enq;
    logic issue;
    logic unused_ir_bits;

    assign head_ir_p0  = fifo_ir[rd_ptr];
    assign head_ia_p0  = fifo_ia[rd_ptr];
    assign head_vld_p0 = (count != '0);

    assign opc_p0 = head_ir_p0[6:0];
    assign rd_p0  = head_ir_p0[7  +: REG_AW];
    assign ra_p0  = head_ir_p0[12 +: REG_AW];
    assign rb_p0  = head_ir_p0[27 +: REG_AW];

    // Instruction bits that play no part in hazard decoding
    assign unused_ir_bits = ^{head_ir_p0[26:20], head_ir_p0[18:17]};

    // Classify the head instruction: which registers it reads and writes
    always_comb begin
        src_a_en_p0 = 1'b0;
        src_b_en_p0 = 1'b0;
        src_b_p0    = rb_p0;
        wr_en_p0    = 1'b0;
        dest_p0     = rd_p0;
        if (!opc_p0[6]) begin
            src_a_en_p0 = 1'b1;
            src_b_en_p0 = 1'b1;
            wr_en_p0    = 1'b1;
        end else if (opc_p0 == OPC_STORE) begin
            // stores read the data register from the rd field
            src_a_en_p0 = 1'b1;
            src_b_en_p0 = 1'b1;
            src_b_p0    = rd_p0;
        end else if (opc_p0[6:1] == OPC_NOSRC) begin
            wr_en_p0    = 1'b1;
        end else if (opc_p0 == OPC_BRANCH) begin
            // ir[19] marks a call, which links into the top register
            wr_en_p0    = head_ir_p0[19];
            dest_p0     = REG_AW'(NUM_REGS - 1);
        end else begin
            src_a_en_p0 = 1'b1;
            wr_en_p0    = 1'b1;
        end
    end

    assign wr_eff_p0 = wr_en_p0 && (dest_p0 != '0);

    // RAW on either source or WAW on the destination; r0 never hazards
    assign hazard_p0 = (src_a_en_p0 && (ra_p0    != '0) && scoreboard[ra_p0])
                     | (src_b_en_p0 && (src_b_p0 != '0) && scoreboard[src_b_p0])
                     | (wr_eff_p0   && scoreboard[dest_p0]);

    assign stall_hazard = head_vld_p0 && hazard_p0;
    assign if_ready     = (count < CNT_W'(DEPTH)) && !flush && !rst;
    assign enq          = if_valid && if_ready;
    assign issue        = !flush && head_vld_p0 && !hazard_p0 && (!ex_valid || ex_ready);
    assign occupancy    = count;

    // Write the fetched instruction into the tail slot
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_ir[wr_ptr] <= if_ir;
            fifo_ia[wr_ptr] <= if_ia_plus_4;
        end
    end

    // Queue pointers and fill level; flush discards everything queued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({enq, issue})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Next scoreboard: retire, then un-mark a flushed holder, then mark the issuer
    always_comb begin
        scoreboard_next = scoreboard;
        if (wb_valid && (wb_addr != '0)) begin
            scoreboard_next[wb_addr] = 1'b0;
        end
        if (flush && ex_valid && (ex_dest_p1 != '0)) begin
            scoreboard_next[ex_dest_p1] = 1'b0;
        end
        if (issue && wr_eff_p0) begin
            scoreboard_next[dest_p0] = 1'b1;
        end
        scoreboard_next[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scoreboard <= '0;
        end else begin
            scoreboard <= scoreboard_next;
        end
    end

    // ---- stage p0 -> p1: registered issue slot toward EX ----
    // Load on issue, drop on consume or flush, hold while EX back-pressures
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_ir        <= '0;
            ex_ia_plus_4 <= '0;
            ex_dest_p1   <= '0;
        end else if (flush) begin
            ex_valid     <= 1'b0;
            ex_dest_p1   <= '0;
        end else if (issue) begin
            ex_valid     <= 1'b1;
            ex_ir        <= head_ir_p0;
            ex_ia_plus_4 <= head_ia_p0;
            ex_dest_p1   <= wr_eff_p0 ? dest_p0 : '0;
        end else if (ex_ready) begin
            ex_valid     <= 1'b0;
        end
    end

endmodule
